// File: rtl/vend_ctrl_if.sv
// Coin/purchase strobe and status bundle between the button/coin decode logic and vend_ctrl.
// The master drives the strobes; the slave (vend_ctrl) drives the registered status outputs.
interface vend_ctrl_if;
    logic       coin_valid;
    logic [1:0] coin_val;
    logic       buy;
    logic [2:0] item;
    logic       cancel;
    logic [7:0] credit;
    logic       dispense;
    logic [2:0] disp_item;
    logic [7:0] change;
    logic       coin_reject;
    logic [2:0] state;

    modport master (
        output coin_valid, coin_val, buy, item, cancel,
        input  credit, dispense, disp_item, change, coin_reject, state
    );

    modport slave (
        input  coin_valid, coin_val, buy, item, cancel,
        output credit, dispense, disp_item, change, coin_reject, state
    );
endinterface

// File: rtl/vend_ctrl.sv
// Vending machine transaction sequencer: credit accumulation, purchase, refund and change.
// Optional macro AUTO_REFUND_EN adds an idle timeout in MONEY that refunds like a cancel.
module vend_ctrl #(
    parameter logic [7:0] ITEM_PRICE = 8'd75,
    parameter logic [7:0] MAX_CREDIT = 8'd200,
    parameter int         HOLD_TICKS = 100
`ifdef AUTO_REFUND_EN
    ,
    parameter int         TIMEOUT_TICKS = 3000
`endif
) (
    input  logic       hz100,
    input  logic       reset,
    vend_ctrl_if.slave vif
);

    typedef enum logic [2:0] {
        INIT      = 3'd0,
        MONEY     = 3'd1,
        PURCHASED = 3'd2,
        REJECTION = 3'd3,
        REFUND    = 3'd4
    } state_e;

    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS - 1);

    state_e        state_q, state_d;
    logic [7:0]    credit_q, credit_d;
    logic [7:0]    change_q, change_d;
    logic [2:0]    disp_item_q, disp_item_d;
    logic          dispense_q, dispense_d;
    logic          coin_reject_q, coin_reject_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0]    coinAmt;
    logic [8:0]    sum9;
    logic          timeoutHit;

`ifdef AUTO_REFUND_EN
    localparam int IW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
    logic [IW-1:0] idle_q, idle_d;
`endif

    always_comb begin
        case (vif.coin_val)
            2'd0:    coinAmt = 8'd5;
            2'd1:    coinAmt = 8'd10;
            2'd2:    coinAmt = 8'd25;
            default: coinAmt = 8'd100;
        endcase
        sum9 = {1'b0, credit_q} + {1'b0, coinAmt};

`ifdef AUTO_REFUND_EN
        timeoutHit = (state_q == MONEY) && (idle_q == IW'(TIMEOUT_TICKS - 1));
`else
        timeoutHit = 1'b0;
`endif

        state_d       = state_q;
        credit_d      = credit_q;
        change_d      = change_q;
        disp_item_d   = disp_item_q;
        dispense_d    = 1'b0;
        coin_reject_d = 1'b0;
        hold_d        = hold_q;

        case (state_q)
            INIT: begin
                // Arbitration applies even though cancel has no effect here.
                coin_reject_d = vif.coin_valid && (vif.buy || vif.cancel);
                if (vif.buy) begin
                    state_d = REJECTION;
                    hold_d  = HOLD_LOAD;
                end else if (vif.coin_valid && !vif.cancel) begin
                    state_d  = MONEY;
                    credit_d = coinAmt;
                end
            end
            MONEY: begin
                coin_reject_d = vif.coin_valid && (vif.buy || vif.cancel || timeoutHit);
                if (vif.cancel || timeoutHit) begin
                    state_d  = REFUND;
                    change_d = credit_q;
                    credit_d = 8'd0;
                    hold_d   = HOLD_LOAD;
                end else if (vif.buy) begin
                    hold_d = HOLD_LOAD;
                    if (credit_q >= ITEM_PRICE) begin
                        state_d     = PURCHASED;
                        dispense_d  = 1'b1;
                        disp_item_d = vif.item;
                        change_d    = credit_q - ITEM_PRICE;
                        credit_d    = 8'd0;
                    end else begin
                        state_d = REJECTION;
                    end
                end else if (vif.coin_valid) begin
                    if (sum9 <= {1'b0, MAX_CREDIT}) begin
                        credit_d = sum9[7:0];
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            PURCHASED, REJECTION, REFUND: begin
                coin_reject_d = vif.coin_valid;
                if (hold_q == '0) begin
                    change_d = 8'd0;
                    if (state_q == REJECTION && credit_q != 8'd0) begin
                        state_d = MONEY;
                    end else begin
                        state_d = INIT;
                    end
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            default: begin
                state_d     = INIT;
                credit_d    = 8'd0;
                change_d    = 8'd0;
                disp_item_d = 3'd0;
                hold_d      = '0;
            end
        endcase

`ifdef AUTO_REFUND_EN
        // Counts only uninterrupted idle cycles spent inside MONEY.
        if (state_q == MONEY && state_d == MONEY && !vif.coin_valid && !vif.buy) begin
            idle_d = idle_q + IW'(1);
        end else begin
            idle_d = '0;
        end
`endif
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            state_q       <= INIT;
            credit_q      <= 8'd0;
            change_q      <= 8'd0;
            disp_item_q   <= 3'd0;
            dispense_q    <= 1'b0;
            coin_reject_q <= 1'b0;
            hold_q        <= '0;
`ifdef AUTO_REFUND_EN
            idle_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            change_q      <= change_d;
            disp_item_q   <= disp_item_d;
            dispense_q    <= dispense_d;
            coin_reject_q <= coin_reject_d;
            hold_q        <= hold_d;
`ifdef AUTO_REFUND_EN
            idle_q        <= idle_d;
`endif
        end
    end

    assign vif.state       = state_q;
    assign vif.credit      = credit_q;
    assign vif.change      = change_q;
    assign vif.disp_item   = disp_item_q;
    assign vif.dispense    = dispense_q;
    assign vif.coin_reject = coin_reject_q;

endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
- Transaction sequencer for the vending machine. Accumulates inserted coin credit, evaluates purchase requests against a fixed price, and issues dispense, change and refund commands.
- Sits between the debounced push-button/coin decode logic and the seven-segment/LED display logic inside top.
- Clocked from the 100 Hz board clock.

Parameters:
- ITEM_PRICE, 8'd75: price of any item, in cents.
- MAX_CREDIT, 8'd200: credit ceiling in cents; a coin that would exceed it is refused.
- HOLD_TICKS, 100: cycles spent in each terminal display state (1 s at 100 Hz); must be >= 1.
- TIMEOUT_TICKS, 3000: idle cycles in MONEY before auto-refund; used only with AUTO_REFUND_EN.

Ports:
- hz100  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- coin_valid  in  1  single-cycle coin-insert strobe.
- coin_val  in  2  coin code: 0=5, 1=10, 2=25, 3=100 cents.
- buy  in  1  single-cycle purchase strobe.
- item  in  3  selected item index; sampled when buy is accepted.
- cancel  in  1  single-cycle cancel/refund strobe.
- credit  out  8  current credit, in cents.
- dispense  out  1  one-cycle pulse on a successful purchase.
- disp_item  out  3  item latched at purchase; held until the next purchase.
- change  out  8  change/refund amount in cents; valid while in PURCHASED or REFUND.
- coin_reject  out  1  one-cycle pulse when a coin is refused.
- state  out  3  current state: INIT=0, MONEY=1, PURCHASED=2, REJECTION=3, REFUND=4.

Behaviour:
- Reset (synchronous, has priority over everything):
  - state=INIT; credit=0, change=0, disp_item=0; dispense=0, coin_reject=0; hold and idle counters=0.
- All outputs are registered. Every response appears on the cycle after the input strobe.
- Priority among strobes in the same cycle: cancel > buy > coin_valid. A coin_valid that loses arbitration produces a coin_reject pulse, and credit is unchanged.
- INIT:
  - coin -> MONEY, credit=coin value.
  - buy -> REJECTION.
  - cancel is ignored.
- MONEY:
  - coin: if credit+value <= MAX_CREDIT, credit += value. Otherwise pulse coin_reject and leave credit unchanged. Compute the sum at 9 bits; no wraparound.
  - buy with credit >= ITEM_PRICE -> PURCHASED: dispense pulse, disp_item=item, change=credit-ITEM_PRICE, credit=0.
  - buy with credit < ITEM_PRICE -> REJECTION; credit unchanged.
  - cancel -> REFUND: change=credit, credit=0.
- PURCHASED, REJECTION, REFUND:
  - Load the hold counter with HOLD_TICKS-1 on entry. Exit when it reaches 0, so each of these states lasts exactly HOLD_TICKS cycles.
  - buy and cancel are ignored. A coin is refused with a coin_reject pulse.
  - Exits:
    - PURCHASED -> INIT, change=0.
    - REFUND -> INIT, change=0.
    - REJECTION -> MONEY if credit>0, else INIT.
- Credit exactly equal to ITEM_PRICE: purchase succeeds with change=0.
- Reset asserted mid-hold: returns to INIT next cycle. Any credit and pending change are discarded.
- Unused state encodings 5-7 go to INIT on the next cycle, with all outputs at reset values.

Optional Feature:
- Macro: AUTO_REFUND_EN.
- When defined:
  - An idle counter clears on entry to MONEY and on every coin/buy strobe, and increments each cycle in MONEY.
  - When it reaches TIMEOUT_TICKS-1, go to REFUND exactly as for cancel.
  - cancel in the same cycle as the timeout gives identical behaviour.
- When undefined: no idle counter is built, and MONEY persists indefinitely.

Test Plan:
- reset, then quarter x3, then buy item=2 -> credit 25/50/75; dispense pulse one cycle after buy; disp_item=2; change=0; state=2 for 100 cycles, then 0.
- dollar, then buy item=5 -> dispense; change=25; credit=0; after hold, state=0 and change=0.
- dime, then buy -> state=3 for 100 cycles, then state=1 with credit=10. Follow with cancel -> state=4, change=10, then state=0.
- dollar x2, then nickel -> credit=200; coin_reject pulse; credit stays 200. Then buy and coin in the same cycle -> purchase with change=125, plus coin_reject pulse.
- quarter, then cancel+buy+coin in the same cycle -> REFUND with change=25, coin_reject pulse, no dispense. Assert reset during the hold -> next cycle state=0, change=0.
- AUTO_REFUND_EN, TIMEOUT_TICKS=10: dime, then idle -> REFUND entered 10 cycles after entering MONEY, change=10. Inserting a coin at cycle 8 restarts the count.
